// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, funct3 codes
// and TX_STATUS bit positions.
package dmem_pkg;

    localparam logic [9:0] TIMER_OFS = 10'h000;
    localparam logic [9:0] GPIO_OFS  = 10'h004;
    localparam logic [9:0] TXD_OFS   = 10'h008;
    localparam logic [9:0] TXS_OFS   = 10'h00C;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TXS_FULL_BIT  = 0;
    localparam int TXS_EMPTY_BIT = 1;
    localparam int TXS_COUNT_LSB = 2;
    localparam int TXS_OVF_BIT   = 5;

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Synchronous FIFO with push/pop, full/empty and occupancy count.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_push_ok,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    always_comb begin
        o_full    = (count_q == CNT_W'(DEPTH));
        o_empty   = (count_q == '0);
        pop_ok    = i_pop && !o_empty;
        push_ok   = i_push && (!o_full || pop_ok);
        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        o_push_ok = push_ok;
        o_count   = count_q;
        o_head    = mem_q[rd_ptr_q];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: byte-lane RAM below the address MSB, timer/GPIO/TX FIFO
// registers above it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11,
    parameter int P_TX_DEPTH        = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_dmem_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
    input  logic [2:0]                   i_dmem_f3,
    output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
    output logic [P_DATA_WIDTH-1:0]      o_gpio,
    output logic                         o_tx_valid,
    output logic [7:0]                   o_tx_data,
    input  logic                         i_tx_ready
);

    localparam int IDX_W     = P_DMEM_ADDR_WIDTH - 3;
    localparam int RAM_WORDS = 1 << IDX_W;
    localparam int CNT_W     = $clog2(P_TX_DEPTH) + 1;

    logic [3:0][7:0]   ram_q [RAM_WORDS];
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       gpio_q, gpio_d;
    logic              ovf_q, ovf_d;

    logic              is_mmio;
    logic [IDX_W-1:0]  word_idx;
    logic              sel_timer, sel_gpio, sel_txd, sel_txs;
    logic [3:0]        lane_en;
    logic [3:0][7:0]   lane_data;
    logic              ram_we;
    logic              tx_push, tx_pop, tx_push_ok, tx_drop, txs_clear;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [2:0]        status_count;
    logic [31:0]       mmio_word, raw_word, shifted_b, shifted_h;

    always_comb begin
        is_mmio   = i_dmem_addr[P_DMEM_ADDR_WIDTH-1];
        word_idx  = i_dmem_addr[P_DMEM_ADDR_WIDTH-2:2];
        sel_timer = is_mmio && (word_idx == IDX_W'(TIMER_OFS >> 2));
        sel_gpio  = is_mmio && (word_idx == IDX_W'(GPIO_OFS >> 2));
        sel_txd   = is_mmio && (word_idx == IDX_W'(TXD_OFS >> 2));
        sel_txs   = is_mmio && (word_idx == IDX_W'(TXS_OFS >> 2));
    end

    // Store data is replicated across lanes so the enables alone pick the target bytes.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = i_dmem_wdata;
        case (i_dmem_f3)
            F3_B, F3_BU: begin
                lane_en   = 4'b0001 << i_dmem_addr[1:0];
                lane_data = {4{i_dmem_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                lane_en   = i_dmem_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{i_dmem_wdata[15:0]}};
            end
            F3_W: begin
                lane_en   = 4'b1111;
                lane_data = i_dmem_wdata;
            end
            default: begin
                lane_en   = 4'b0000;
                lane_data = i_dmem_wdata;
            end
        endcase
        ram_we = i_dmem_we && !is_mmio;
    end

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_en[l]) begin
                    ram_q[word_idx][l] <= lane_data[l];
                end
            end
        end
    end

    always_comb begin
        tx_pop    = o_tx_valid && i_tx_ready;
        tx_push   = i_dmem_we && sel_txd;
        txs_clear = i_dmem_we && sel_txs;
        tx_drop   = tx_push && !tx_push_ok;
        timer_d   = timer_q + 32'd1;
        gpio_d    = (i_dmem_we && sel_gpio) ? i_dmem_wdata : gpio_q;
        ovf_d     = tx_drop ? 1'b1 : (txs_clear ? 1'b0 : ovf_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q <= '0;
            gpio_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            gpio_q  <= gpio_d;
            ovf_q   <= ovf_d;
        end
    end

    tx_fifo #(
        .DATA_W (8),
        .DEPTH  (P_TX_DEPTH)
    ) u_tx_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (tx_push),
        .i_push_data (i_dmem_wdata[7:0]),
        .i_pop       (tx_pop),
        .o_push_ok   (tx_push_ok),
        .o_head      (o_tx_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    // Sub-word reads return the selected byte/half zero-filled; extension happens downstream.
    always_comb begin
        status_count = 3'(fifo_count);
        mmio_word    = '0;
        if (sel_timer) begin
            mmio_word = timer_q;
        end else if (sel_gpio) begin
            mmio_word = gpio_q;
        end else if (sel_txs) begin
            mmio_word[TXS_FULL_BIT]                    = fifo_full;
            mmio_word[TXS_EMPTY_BIT]                   = fifo_empty;
            mmio_word[TXS_COUNT_LSB+2:TXS_COUNT_LSB]   = status_count;
            mmio_word[TXS_OVF_BIT]                     = ovf_q;
        end
        raw_word  = is_mmio ? mmio_word : ram_q[word_idx];
        shifted_b = raw_word >> {i_dmem_addr[1:0], 3'b000};
        shifted_h = raw_word >> {i_dmem_addr[1], 4'b0000};
        case (i_dmem_f3)
            F3_B, F3_BU: o_dmem_rdata = {24'b0, shifted_b[7:0]};
            F3_H, F3_HU: o_dmem_rdata = {16'b0, shifted_h[15:0]};
            default:     o_dmem_rdata = raw_word;
        endcase
        o_gpio     = gpio_q;
        o_tx_valid = !fifo_empty;
    end

endmodule
